// File: rtl/sh_frame_capture_if.sv
// rtl/sh_frame_capture_if.sv - drain-side valid/ready port of the SH frame capture block
interface sh_frame_capture_if #(
  parameter int W  = 8,
  parameter int IW = 6
);
  logic [W-1:0]  q;
  logic [IW-1:0] qidx;
  logic          qv;
  logic          qr;
  logic          qlast;

  modport master (output q, output qidx, output qv, output qlast, input qr);
  modport slave  (input q, input qidx, input qv, input qlast, output qr);
endinterface

// File: rtl/sh_frame_capture.sv
// rtl/sh_frame_capture.sv - captures thermometer-addressed samples into frames and drains them word by word
module sh_frame_capture #(
  parameter int SIZE = 80,
  parameter int D    = 4,
  parameter int BR   = 2,
  // SIZE elements fan over BR branches of depth D: 10 taps, 40 slots per frame
  parameter int T    = SIZE / (BR * D),
  parameter int W    = 8,
  localparam int N   = T * D,
  localparam int IW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       sh,
  input  logic [W-1:0]       din,
  input  logic               clr,
  output logic [3:0]         qf,
  output logic               ovf,
  output logic               badseq,
  sh_frame_capture_if.master drain
);

  typedef enum logic [1:0] {C_IDLE, C_FILL, C_DONE} cap_state_t;
  typedef enum logic {D_EMPTY, D_DRAIN} drn_state_t;

  localparam int             CW   = $clog2(N + 1);
  localparam logic [N-1:0]   ONE  = N'(1);
  localparam logic [IW-1:0]  LAST = IW'(N - 1);

  cap_state_t    cap_state, cap_next;
  drn_state_t    drn_state, drn_next;
  logic [N-1:0]  sh_d;
  logic [W-1:0]  cbank [N];
  logic [W-1:0]  obank [N];

  logic [IW-1:0] k;
  logic [CW-1:0] cnt_sh, cnt_d;
  logic          thermo, shrink, grow, jump, sh_zero;
  logic          wr_en, complete, bad_evt, qf_clear;
  logic [3:0]    qf_hit;
  logic          hs, at_last, load, ovf_evt;
  logic [IW-1:0] next_idx;

  // Leading one of SH and how SH moved relative to the previous sample
  always_comb begin
    k = '0;
    for (int i = 0; i < N; i++)
      if (sh[i]) k = IW'(i);
    cnt_sh  = CW'($countones(sh));
    cnt_d   = CW'($countones(sh_d));
    sh_zero = (sh == '0);
    thermo  = ((sh & (sh + ONE)) == '0);
    shrink  = !sh_zero && (cnt_sh < cnt_d);
    grow    = (cnt_sh > cnt_d);
    jump    = grow && ((cnt_sh - cnt_d) > CW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_state <= C_IDLE;
      drn_state <= D_EMPTY;
    end else begin
      cap_state <= cap_next;
      drn_state <= drn_next;
    end
  end

  always_comb begin
    cap_next = cap_state;
    case (cap_state)
      C_IDLE, C_FILL: begin
        if (sh_zero)
          cap_next = C_IDLE;
        else if ((thermo && shrink) || complete)
          cap_next = C_DONE;
        else if (wr_en)
          cap_next = C_FILL;
      end
      default: if (sh_zero) cap_next = C_IDLE;
    endcase
  end

  always_comb begin
    wr_en    = 1'b0;
    bad_evt  = 1'b0;
    qf_clear = 1'b0;
    if (cap_state != C_DONE && !sh_zero) begin
      if (!thermo || shrink) begin
        bad_evt = 1'b1;
      end else if (cap_state == C_IDLE || grow) begin
        wr_en   = 1'b1;
        bad_evt = jump;
      end
    end
    if (cap_state == C_IDLE && wr_en)
      qf_clear = 1'b1;
    if (cap_state == C_FILL && sh_zero)
      qf_clear = 1'b1;
    complete = wr_en && (k == LAST);
    for (int i = 0; i < 4; i++)
      qf_hit[i] = wr_en && (k == IW'((i + 1) * N / 4 - 1));
  end

  assign hs       = drain.qv && drain.qr;
  assign at_last  = (drain.qidx == LAST);
  assign next_idx = drain.qidx + IW'(1);
  // A final handshake frees the output bank on the same edge a new frame lands
  assign load     = complete && (drn_state == D_EMPTY || (hs && at_last));
  assign ovf_evt  = complete && !load;

  always_comb begin
    drn_next = drn_state;
    case (drn_state)
      D_EMPTY: if (load) drn_next = D_DRAIN;
      default: if (hs && at_last && !load) drn_next = D_EMPTY;
    endcase
  end

  always_comb begin
    drain.qv    = (drn_state == D_DRAIN);
    drain.qlast = (drn_state == D_DRAIN) && at_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_d       <= '0;
      qf         <= '0;
      ovf        <= 1'b0;
      badseq     <= 1'b0;
      drain.q    <= '0;
      drain.qidx <= '0;
    end else begin
      sh_d   <= sh;
      qf     <= qf_clear ? qf_hit : (qf | qf_hit);
      ovf    <= ovf_evt | (ovf & ~clr);
      badseq <= bad_evt | (badseq & ~clr);
      if (load) begin
        drain.qidx <= '0;
        drain.q    <= cbank[0];
      end else if (hs) begin
        if (at_last) begin
          drain.qidx <= '0;
        end else begin
          drain.qidx <= next_idx;
          drain.q    <= obank[next_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      cbank[k] <= din;
    if (load) begin
      for (int i = 0; i < N - 1; i++)
        obank[i] <= cbank[i];
      obank[N-1] <= din;
    end
  end

endmodule

// File: tb/tb_sh_frame_capture.sv
// tb/tb_sh_frame_capture.sv - directed self-checking bench for sh_frame_capture
module tb_sh_frame_capture;
  localparam int N = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic [N-1:0] sh;
  logic [7:0]   din;
  logic [3:0]   qf;
  logic         ovf;
  logic         badseq;
  int           n_cmp = 0;
  int           n_bad = 0;

  sh_frame_capture_if #(.W(8), .IW(6)) drain_if ();

  sh_frame_capture dut (
    .clk(clk), .rst(rst), .sh(sh), .din(din), .clr(clr),
    .qf(qf), .ovf(ovf), .badseq(badseq), .drain(drain_if)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ones(input int n);
    logic [N-1:0] a;
    a = '1;
    return (n == 0) ? '0 : (a >> (N - n));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < N; i++) begin
      sh = ones(i + 1);
      din = 8'(base + i);
      step();
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (drain_if.qv !== 1'b0) begin n_bad++; $display("FAIL reset_qv: got %0b want 0", drain_if.qv); end
    n_cmp++; if (drain_if.qidx !== 6'd0) begin n_bad++; $display("FAIL reset_qidx: got %0d want 0", drain_if.qidx); end
    n_cmp++; if (drain_if.q !== 8'd0) begin n_bad++; $display("FAIL reset_q: got %0d want 0", drain_if.q); end
    n_cmp++; if (drain_if.qlast !== 1'b0) begin n_bad++; $display("FAIL reset_qlast: got %0b want 0", drain_if.qlast); end
    n_cmp++; if (qf !== 4'd0) begin n_bad++; $display("FAIL reset_qf: got %b want 0000", qf); end
    n_cmp++; if (ovf !== 1'b0 || badseq !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got ovf=%0b badseq=%0b want 0 0", ovf, badseq); end
  endtask

  task automatic test_basic();
    drain_if.qr = 1'b1;
    for (int i = 0; i < N; i++) begin
      sh = ones(i + 1);
      din = 8'(i);
      if (i == N - 1) begin
        n_cmp++; if (drain_if.qv !== 1'b0) begin n_bad++; $display("FAIL basic_qv_early: got %0b want 0", drain_if.qv); end
      end
      step();
      if (i == 9) begin
        n_cmp++; if (qf !== 4'b0001) begin n_bad++; $display("FAIL basic_qf_q0: got %b want 0001", qf); end
      end
    end
    n_cmp++; if (drain_if.qv !== 1'b1) begin n_bad++; $display("FAIL basic_qv_rise: got %0b want 1", drain_if.qv); end
    for (int j = 0; j < N; j++) begin
      n_cmp++; if (drain_if.q !== 8'(j) || drain_if.qidx !== 6'(j)) begin n_bad++; $display("FAIL basic_word[%0d]: got q=%0d qidx=%0d want %0d", j, drain_if.q, drain_if.qidx, j); end
      n_cmp++; if (drain_if.qlast !== (j == N - 1)) begin n_bad++; $display("FAIL basic_qlast[%0d]: got %0b want %0b", j, drain_if.qlast, (j == N - 1)); end
      step();
    end
    n_cmp++; if (drain_if.qv !== 1'b0) begin n_bad++; $display("FAIL basic_qv_end: got %0b want 0", drain_if.qv); end
    n_cmp++; if (ovf !== 1'b0 || qf !== 4'hf) begin n_bad++; $display("FAIL basic_flags: got ovf=%0b qf=%b want 0 1111", ovf, qf); end
    sh = '0;
    step();
  endtask

  task automatic test_backpressure();
    int j;
    int c;
    drain_if.qr = 1'b0;
    fill(100);
    n_cmp++; if (drain_if.qv !== 1'b1) begin n_bad++; $display("FAIL bp_qv: got %0b want 1", drain_if.qv); end
    j = 0;
    c = 0;
    while (j < N && c < 200) begin
      drain_if.qr = (c % 2 == 0);
      n_cmp++; if (drain_if.q !== 8'(100 + j) || drain_if.qidx !== 6'(j)) begin n_bad++; $display("FAIL bp_word[%0d]: got q=%0d qidx=%0d want q=%0d qidx=%0d", c, drain_if.q, drain_if.qidx, 100 + j, j); end
      step();
      if (drain_if.qr) j++;
      c++;
    end
    n_cmp++; if (j != N) begin n_bad++; $display("FAIL bp_timeout: got %0d words want %0d", j, N); end
    n_cmp++; if (drain_if.qv !== 1'b0) begin n_bad++; $display("FAIL bp_qv_end: got %0b want 0", drain_if.qv); end
    drain_if.qr = 1'b0;
    sh = '0;
    step();
  endtask

  task automatic test_abort();
    drain_if.qr = 1'b1;
    for (int i = 0; i < 17; i++) begin
      sh = ones(i + 1);
      din = 8'(i);
      step();
    end
    n_cmp++; if (qf !== 4'b0001) begin n_bad++; $display("FAIL abort_qf_partial: got %b want 0001", qf); end
    sh = '0;
    step();
    n_cmp++; if (qf !== 4'b0000) begin n_bad++; $display("FAIL abort_qf_clear: got %b want 0000", qf); end
    step(); step(); step();
    n_cmp++; if (drain_if.qv !== 1'b0) begin n_bad++; $display("FAIL abort_no_qv: got %0b want 0", drain_if.qv); end
    fill(50);
    n_cmp++; if (drain_if.qv !== 1'b1) begin n_bad++; $display("FAIL abort_next_qv: got %0b want 1", drain_if.qv); end
    for (int j = 0; j < N; j++) begin
      n_cmp++; if (drain_if.q !== 8'(50 + j)) begin n_bad++; $display("FAIL abort_next_word[%0d]: got %0d want %0d", j, drain_if.q, 50 + j); end
      step();
    end
    n_cmp++; if (drain_if.qv !== 1'b0) begin n_bad++; $display("FAIL abort_next_end: got %0b want 0", drain_if.qv); end
    sh = '0;
    step();
  endtask

  task automatic test_overflow();
    drain_if.qr = 1'b0;
    fill(32);
    sh = '0;
    step();
    fill(128);
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %0b want 1", ovf); end
    n_cmp++; if (drain_if.qv !== 1'b1 || drain_if.q !== 8'd32 || drain_if.qidx !== 6'd0) begin n_bad++; $display("FAIL ovf_first_intact: got qv=%0b q=%0d qidx=%0d want 1 32 0", drain_if.qv, drain_if.q, drain_if.qidx); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clr: got %0b want 0", ovf); end
    drain_if.qr = 1'b1;
    for (int j = 0; j < N; j++) begin
      n_cmp++; if (drain_if.q !== 8'(32 + j)) begin n_bad++; $display("FAIL ovf_word[%0d]: got %0d want %0d", j, drain_if.q, 32 + j); end
      step();
    end
    n_cmp++; if (drain_if.qv !== 1'b0) begin n_bad++; $display("FAIL ovf_drain_end: got %0b want 0", drain_if.qv); end
    drain_if.qr = 1'b0;
    sh = '0;
    step();
  endtask

  task automatic test_back_to_back();
    drain_if.qr = 1'b0;
    fill(64);
    n_cmp++; if (drain_if.qv !== 1'b1) begin n_bad++; $display("FAIL b2b_first_qv: got %0b want 1", drain_if.qv); end
    sh = '0;
    step();
    for (int i = 0; i < N; i++) begin
      sh = ones(i + 1);
      din = 8'(160 + i);
      drain_if.qr = 1'b1;
      n_cmp++; if (drain_if.q !== 8'(64 + i) || drain_if.qidx !== 6'(i)) begin n_bad++; $display("FAIL b2b_old_word[%0d]: got q=%0d qidx=%0d want q=%0d qidx=%0d", i, drain_if.q, drain_if.qidx, 64 + i, i); end
      step();
    end
    n_cmp++; if (drain_if.qv !== 1'b1 || drain_if.qidx !== 6'd0) begin n_bad++; $display("FAIL b2b_handover: got qv=%0b qidx=%0d want 1 0", drain_if.qv, drain_if.qidx); end
    n_cmp++; if (drain_if.q !== 8'd160 || ovf !== 1'b0) begin n_bad++; $display("FAIL b2b_new_data: got q=%0d ovf=%0b want 160 0", drain_if.q, ovf); end
    for (int j = 0; j < N; j++) begin
      n_cmp++; if (drain_if.q !== 8'(160 + j)) begin n_bad++; $display("FAIL b2b_new_word[%0d]: got %0d want %0d", j, drain_if.q, 160 + j); end
      step();
    end
    n_cmp++; if (drain_if.qv !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got %0b want 0", drain_if.qv); end
    drain_if.qr = 1'b0;
    sh = '0;
    step();
  endtask

  task automatic test_badseq();
    n_cmp++; if (badseq !== 1'b0) begin n_bad++; $display("FAIL bad_initial: got %0b want 0", badseq); end
    for (int i = 1; i <= 3; i++) begin
      sh = ones(i);
      din = 8'(i);
      step();
    end
    n_cmp++; if (badseq !== 1'b0) begin n_bad++; $display("FAIL bad_clean_growth: got %0b want 0", badseq); end
    sh = ones(5);
    step();
    n_cmp++; if (badseq !== 1'b1) begin n_bad++; $display("FAIL bad_jump: got %0b want 1", badseq); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_cmp++; if (badseq !== 1'b0) begin n_bad++; $display("FAIL bad_clr: got %0b want 0", badseq); end
    sh = 40'b101;
    step();
    n_cmp++; if (badseq !== 1'b1) begin n_bad++; $display("FAIL bad_not_thermo: got %0b want 1", badseq); end
    sh = '0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_cmp++; if (badseq !== 1'b0) begin n_bad++; $display("FAIL bad_clr2: got %0b want 0", badseq); end
    drain_if.qr = 1'b0;
    fill(0);
    drain_if.qr = 1'b1;
    step(); step(); step();
    drain_if.qr = 1'b0;
    n_cmp++; if (drain_if.qv !== 1'b1 || drain_if.qidx !== 6'd3) begin n_bad++; $display("FAIL rst_pre: got qv=%0b qidx=%0d want 1 3", drain_if.qv, drain_if.qidx); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (drain_if.qv !== 1'b0 || drain_if.qidx !== 6'd0) begin n_bad++; $display("FAIL rst_async: got qv=%0b qidx=%0d want 0 0", drain_if.qv, drain_if.qidx); end
    step();
    rst = 1'b0;
    sh = '0;
    step();
    n_cmp++; if (drain_if.qv !== 1'b0) begin n_bad++; $display("FAIL rst_after: got %0b want 0", drain_if.qv); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    sh = '0;
    din = '0;
    drain_if.qr = 1'b0;
    step();
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_basic();
    test_backpressure();
    test_abort();
    test_overflow();
    test_back_to_back();
    test_badseq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
